gb_stream_sched: RTL and testbench

Sequencing controller for the 9x9 Gaussian-blur stencil datapath. Tracks the pixel position of the incoming AXI-stream. Drives line-buffer write select and address, and decides when the 9x9 window is valid. Runs the input/output stream handshakes and counts completed frames. It sits between the stream ports and the line-buffer/stencil/gb_fun datapath, which carries no control of its own.

---
 rtl/gb_pkg.sv | 18 +
 rtl/gb_stream_sched_if.sv | 25 ++
 rtl/gb_pos_counter.sv | 50 +++++
 rtl/gb_stream_sched.sv | 99 +++++++++
 tb/tb_gb_stream_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/gb_pkg.sv
// Shared constants, widths and state type for the 9x9 Gaussian-blur stream sequencer.
package gb_pkg;
    localparam int COLS   = 488;
    localparam int ROWS   = 648;
    localparam int K      = 9;
    localparam int LB_NUM = 8;

    localparam int X_W   = 9;
    localparam int Y_W   = 10;
    localparam int SEL_W = 3;
    localparam int FRM_W = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        EOF    = 2'd2
    } gb_state_t;
endpackage

// File: rtl/gb_stream_sched_if.sv
// Stream handshakes plus line-buffer/stencil control between the scheduler (master) and datapath/ports (slave).
interface gb_stream_sched_if;
    import gb_pkg::*;

    logic             in_tvalid;
    logic             in_tready;
    logic             out_tvalid;
    logic             out_tready;
    logic             lb_wr_en;
    logic [SEL_W-1:0] lb_wr_sel;
    logic [X_W-1:0]   lb_addr;
    logic [Y_W-1:0]   row_cnt;
    logic             win_shift;
    logic             win_fire;

    modport master (
        input  in_tvalid, out_tready,
        output in_tready, out_tvalid, lb_wr_en, lb_wr_sel, lb_addr, row_cnt, win_shift, win_fire
    );

    modport slave (
        output in_tvalid, out_tready,
        input  in_tready, out_tvalid, lb_wr_en, lb_wr_sel, lb_addr, row_cnt, win_shift, win_fire
    );
endinterface

// File: rtl/gb_pos_counter.sv
// Pixel position (x, y) and line-buffer select counters; advance per accepted pixel.
module gb_pos_counter
    import gb_pkg::*;
#(
    parameter int P_COLS = COLS,
    parameter int P_ROWS = ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last_col,
    output logic             o_last_pix
);
    localparam logic [X_W-1:0] X_LAST = X_W'(P_COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(P_ROWS - 1);

    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [SEL_W-1:0] r_sel;
    logic             w_last_col;

    assign w_last_col = (r_x == X_LAST);

    // Select wraps naturally at 8 rows, one buffer per row of the K-1 history.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_x   <= '0;
            r_y   <= '0;
            r_sel <= '0;
        end else if (i_en) begin
            if (w_last_col) begin
                r_x   <= '0;
                r_y   <= r_y + Y_W'(1);
                r_sel <= r_sel + SEL_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_sel      = r_sel;
    assign o_last_col = w_last_col;
    assign o_last_pix = w_last_col && (r_y == Y_LAST);
endmodule

// File: rtl/gb_stream_sched.sv
// Sequencing controller for the 9x9 blur stencil: stream handshakes, window-valid decision, frame count.
//   state  | meaning
//   FILL   | first K-1 rows loading line buffers, no window output
//   STREAM | full window available from x>=K-1
//   EOF    | last pixel taken; drain pending output, then restart frame
module gb_stream_sched
    import gb_pkg::*;
#(
    parameter int P_COLS = COLS,
    parameter int P_ROWS = ROWS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_step,
    gb_stream_sched_if.master   io_strm,
    output logic [FRM_W-1:0]    o_frame_cnt,
    output logic                o_busy
);
    localparam logic [X_W-1:0] X_WIN       = X_W'(K - 1);
    localparam logic [Y_W-1:0] Y_WIN       = Y_W'(K - 1);
    localparam logic [Y_W-1:0] Y_FILL_LAST = Y_W'(K - 2);

    gb_state_t        r_state;
    logic             r_out_vld;
    logic [FRM_W-1:0] r_frame_cnt;

    logic             w_out_free;
    logic             w_in_tready;
    logic             w_acc;
    logic             w_fire;
    logic             w_eof_done;
    logic             w_last_col;
    logic             w_last_pix;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic [SEL_W-1:0] w_sel;

    assign w_out_free  = !r_out_vld || io_strm.out_tready;
    assign w_in_tready = i_step && (r_state != EOF) && w_out_free;
    assign w_acc       = io_strm.in_tvalid && w_in_tready;
    assign w_fire      = w_acc && (w_y >= Y_WIN) && (w_x >= X_WIN);
    assign w_eof_done  = i_step && (r_state == EOF) && w_out_free;

    gb_pos_counter #(
        .P_COLS (P_COLS),
        .P_ROWS (P_ROWS)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_acc),
        .i_clr      (w_eof_done),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_sel      (w_sel),
        .o_last_col (w_last_col),
        .o_last_pix (w_last_pix)
    );

    // A fire takes priority over a drain so back-to-back windows keep the output slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_out_vld   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (i_step) begin
            if (w_fire) begin
                r_out_vld <= 1'b1;
            end else if (io_strm.out_tready) begin
                r_out_vld <= 1'b0;
            end
            case (r_state)
                FILL: begin
                    if (w_acc && w_last_col && (w_y == Y_FILL_LAST)) r_state <= STREAM;
                end
                STREAM: begin
                    if (w_acc && w_last_pix) r_state <= EOF;
                end
                EOF: begin
                    if (w_out_free) begin
                        r_state     <= FILL;
                        r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign io_strm.in_tready  = w_in_tready;
    assign io_strm.out_tvalid = r_out_vld && i_step;
    assign io_strm.lb_wr_en   = w_acc;
    assign io_strm.win_shift  = w_acc;
    assign io_strm.win_fire   = w_fire;
    assign io_strm.lb_wr_sel  = w_sel;
    assign io_strm.lb_addr    = w_x;
    assign io_strm.row_cnt    = w_y;
    assign o_frame_cnt        = r_frame_cnt;
    assign o_busy             = (r_state != FILL) || (w_x != '0) || (w_y != '0);
endmodule

// File: tb/tb_gb_stream_sched.sv
// Bench for gb_stream_sched on a reduced 16x12 frame: per-cycle pixel-index model plus directed literal checks.
module tb_gb_stream_sched;
    import gb_pkg::*;

    localparam int TC   = 16;
    localparam int TR   = 12;
    localparam int NPIX = TC * TR;
    localparam int NOUT = (TR - 8) * (TC - 8);

    logic             clk = 1'b0;
    logic             rst;
    logic             step;
    logic [FRM_W-1:0] frame_cnt;
    logic             busy;

    gb_stream_sched_if sif ();

    gb_stream_sched #(
        .P_COLS (TC),
        .P_ROWS (TR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_step      (step),
        .io_strm     (sif),
        .o_frame_cnt (frame_cnt),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Model: frame progress is just the count of pixels accepted so far.
    int m_idx    = 0;
    int m_frames = 0;
    bit m_pend   = 0;
    bit mon_en   = 0;

    int n_acc      = 0;
    int n_out      = 0;
    int n_blk      = 0;
    int first_fire = -1;

    always @(negedge clk) begin
        int  x, y, est;
        bit  eof, etr, eacc, efire, edone;
        if (mon_en) begin
            x     = m_idx % TC;
            y     = m_idx / TC;
            eof   = (m_idx == NPIX);
            etr   = step && !eof && (!m_pend || sif.out_tready);
            eacc  = sif.in_tvalid && etr;
            efire = eacc && (x >= K - 1) && (y >= K - 1);
            edone = step && eof && (!m_pend || sif.out_tready);
            est   = eof ? 2 : ((m_idx >= (K - 1) * TC) ? 1 : 0);

            check("in_tready",  sif.in_tready,  etr);
            check("out_tvalid", sif.out_tvalid, m_pend && step);
            check("lb_wr_en",   sif.lb_wr_en,   eacc);
            check("win_shift",  sif.win_shift,  eacc);
            check("win_fire",   sif.win_fire,   efire);
            check("lb_addr",    sif.lb_addr,    x);
            check("row_cnt",    sif.row_cnt,    y);
            check("lb_wr_sel",  sif.lb_wr_sel,  y % 8);
            check("frame_cnt",  frame_cnt,      m_frames % 16);
            check("busy",       busy,           m_idx != 0);
            check("state",      dut.r_state,    est);

            if (sif.in_tvalid && sif.in_tready) begin
                if (sif.win_fire && first_fire < 0) first_fire = n_acc;
                n_acc++;
            end
            if (sif.out_tvalid && sif.out_tready) n_out++;
            if (step && !sif.in_tready) n_blk++;

            if (rst) begin
                m_idx = 0; m_pend = 0; m_frames = 0;
            end else if (step) begin
                if (efire) m_pend = 1;
                else if (sif.out_tready) m_pend = 0;
                if (eacc) m_idx++;
                if (edone) begin
                    m_idx = 0;
                    m_frames++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int frames_done;
        logic [FRM_W-1:0] prev;

        rst = 1'b1; step = 1'b0; sif.in_tvalid = 1'b0; sif.out_tready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        mid();
        check("rst_row", sif.row_cnt, 0);
        check("rst_frm", frame_cnt, 0);
        check("rst_out", sif.out_tvalid, 0);
        tick();

        // 1: eight fill rows, no window fires
        step = 1'b1; sif.in_tvalid = 1'b1; sif.out_tready = 1'b1;
        repeat (8 * TC) tick();
        mid();
        check("t1_row8", sif.row_cnt, 8);
        check("t1_sel_wrap", sif.lb_wr_sel, 0);
        check("t1_stream", dut.r_state, 1);
        check("t1_no_fire", first_fire, -1);
        check("t1_acc", n_acc, 8 * TC + 1);

        // 2: first fire at x=8,y=8
        cnt = 0;
        while (first_fire < 0 && cnt < 400) begin
            mid();
            cnt++;
        end
        check("t2_first_fire_idx", first_fire, 8 * TC + 8);
        mid();
        check("t2_out_next", sif.out_tvalid, 1);
        check("t2_addr", sif.lb_addr, 9);
        tick();

        // 4: output backpressure for 5 cycles
        sif.out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("t4_in_tready", sif.in_tready, 0);
            check("t4_out_held", sif.out_tvalid, 1);
            check("t4_x", sif.lb_addr, 10);
            check("t4_y", sif.row_cnt, 8);
            tick();
        end
        sif.out_tready = 1'b1;
        mid();
        check("t4_resume", sif.in_tready, 1);
        check("t4_resume_fire", sif.win_fire, 1);
        tick();

        // 5: step low for 4 cycles
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t5_in_tready", sif.in_tready, 0);
            check("t5_out", sif.out_tvalid, 0);
            check("t5_x", sif.lb_addr, 11);
            check("t5_y", sif.row_cnt, 8);
            tick();
        end
        step = 1'b1;
        n_blk = 0;
        mid();
        check("t5_out_back", sif.out_tvalid, 1);
        check("t5_x_back", sif.lb_addr, 11);

        // 3: finish the frame with sinks always ready
        cnt = 0;
        while (frame_cnt != 4'd1 && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("t3_frame1", frame_cnt, 1);
        check("t3_accepts", n_acc, NPIX);
        check("t3_outputs", n_out, NOUT);
        check("t3_eof_cycles", n_blk, 1);
        mid();
        check("t3_next_x", sif.lb_addr, 0);
        check("t3_next_y", sif.row_cnt, 0);
        check("t3_next_acc", sif.in_tready, 1);

        // 6: reset mid-stream with an output pending, then 16 random frames
        cnt = 0;
        while (!(sif.row_cnt == 10'd9 && sif.lb_addr == 9'd10) && cnt < 500) begin
            tick();
            cnt++;
        end
        rst = 1'b1;
        mid();
        check("t6_pending", sif.out_tvalid, 1);
        tick();
        rst = 1'b0;
        mid();
        check("t6_out_drop", sif.out_tvalid, 0);
        check("t6_x", sif.lb_addr, 0);
        check("t6_y", sif.row_cnt, 0);
        check("t6_frm", frame_cnt, 0);
        check("t6_state", dut.r_state, 0);
        check("t6_busy", busy, 0);

        frames_done = 0;
        prev = frame_cnt;
        cnt = 0;
        while (frames_done < 16 && cnt < 40000) begin
            tick();
            step           = ($urandom_range(0, 9) != 0);
            sif.in_tvalid  = ($urandom_range(0, 3) != 0);
            sif.out_tready = ($urandom_range(0, 3) != 0);
            if (frame_cnt != prev) begin
                frames_done++;
                prev = frame_cnt;
            end
            cnt++;
        end
        check("t6_frames", frames_done, 16);
        check("t6_wrap", frame_cnt, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
